qracc_mac_sequencer: RTL and testbench
======================================

// Module: qracc_mac_sequencer
// PURPOSE
//  Bit-serial controller for the 1-bit bipolar QR accelerator wrapper. It accepts a vector of
//  multi-bit two's-complement activations and drives one bit plane per MAC through data_p/data_n/mac_en.
//  It shift-accumulates the signed per-column ADC codes into multi-bit results.
//  It also arbitrates the shared macro between MAC jobs and host SRAM read/write requests.
// PARAMETERS
//  numRows    128  rows of the analog array (activation vector length)
//  numCols    32   columns (results per job)
//  numAdcBits 4    signed ADC code width (-8..7 at default)
//  inBits     4    max activation precision; accW = numAdcBits+inBits
// PORTS
//  clk            in   1                     clock
//  nrst           in   1                     async active-low reset
//  cfg_in_bits_i  in   $clog2(inBits+1)      runtime precision B; sampled at accept; 0 -> 1, >inBits -> inBits
//  in_valid_i     in   1                     MAC job request
//  in_ready_o     out  1                     job accepted when valid&ready
//  act_i          in   numRows*inBits        activations, row r = act_i[r*inBits +: inBits], signed
//  out_valid_o    out  1                     results valid
//  out_ready_i    in   1                     results consumed when valid&ready
//  result_o       out  numCols*accW          signed per-column accumulated results
//  busy_o         out  1                     state != IDLE
//  mac_en_o       out  1                     to wrapper mac_en_i
//  data_p_o       out  numRows               to wrapper data_p_i (+1 drive)
//  data_n_o       out  numRows               to wrapper data_n_i (-1 drive)
//  adc_i          in   numCols*numAdcBits    from wrapper adc_out_o (signed, registered in wrapper)
//  sram_req_i     in   1                     host wants the SRAM port
//  sram_busy_i    in   1                     wrapper SRAM op in flight (~rq_ready)
//  sram_gnt_o     out  1                     host SRAM request may pass to wrapper this cycle
// BEHAVIOUR
//  Reset: state=IDLE; in_ready_o, out_valid_o, busy_o, mac_en_o, sram_gnt_o = 0.
//   data_p_o, data_n_o, result_o, accumulators, plane counter, and arbitration flag (last=MAC) are all cleared.
//  FSM IDLE -> DRIVE -> CAPTURE -> (DRIVE | DONE) -> IDLE.
//  IDLE: in_ready_o = ~sram_busy_i & ~(sram_req_i & last_was_mac).
//   sram_gnt_o = sram_req_i & ~(in_valid_i & ~last_was_mac).
//   Both request in the same cycle -> the one not served last wins. last_was_mac resets to 1, so SRAM wins first.
//   Accept: latch act_i, latch clamped B, clear acc, plane b=0, go DRIVE.
//  DRIVE (1 cycle): mac_en_o=1.
//   For b<B-1: data_p[r]=act[r][b], data_n=0.
//   For b==B-1 (sign plane): data_n[r]=act[r][B-1], data_p=0.
//  CAPTURE (1 cycle): mac_en_o=0, data_p/n=0. adc_i now holds the plane-b code.
//   acc[c] += sext(adc[c]) <<< b. If b==B-1 go DONE, else b++ and go DRIVE.
//  DONE: result_o=acc, out_valid_o=1, held stable until out_ready_i. Then go IDLE; last_was_mac=1.
//  Outside IDLE: in_ready_o=0 and sram_gnt_o=0. An SRAM grant sets last_was_mac=0.
//  Latency: accept at cycle 0 -> out_valid_o first high at cycle 2B+1. Throughput is one job per 2B+2 cycles minimum.
//  Arithmetic: signed, accW bits, no overflow is possible (|acc| < 2^(accW-1)). Activations above bit B-1 are ignored.
//  Async reset mid-job aborts the job immediately: no out_valid_o, and drives are zeroed.
//  cfg_in_bits_i changes mid-job have no effect.
// TESTING
//  Reset: assert nrst=0 mid-DRIVE (plane 2 of 4) -> same cycle mac_en_o=0, data_p/n=0, busy_o=0; no out_valid_o after release.
//  Positive job: B=4, all act=4'b0011; ADC model returns 3 on planes 0,1 and 0 on planes 2,3 -> every result=9.
//   out_valid_o at cycle 9; data_n_o=0 throughout.
//  Sign plane: B=4, all act=4'b1000; model returns -8 on plane 3 -> data_n_o all ones only in the 4th DRIVE;
//   every result=-64.
//  Clamp: cfg_in_bits_i=0 -> one plane (sign only), out_valid_o at cycle 3. cfg_in_bits_i=7 -> B=4.
//  Backpressure: out_ready_i low 5 cycles -> result_o stable, in_ready_o=0, a pending in_valid_i is not accepted.
//   Job accepted the cycle after DONE->IDLE.
//  Arbitration: after reset, sram_req_i & in_valid_i together -> sram_gnt_o=1, in_ready_o=0.
//   Next conflict -> MAC accepted. sram_busy_i=1 -> in_ready_o=0.

Source files
------------

// File: rtl/qracc_mac_sequencer.sv
// Bit-serial MAC sequencer for the 1-bit bipolar QR macro: drives one activation bit plane per
// MAC, shift-accumulates the signed column ADC codes, and shares the macro with host SRAM traffic.
module qracc_mac_sequencer #(
    parameter int numRows    = 128,
    parameter int numCols    = 32,
    parameter int numAdcBits = 4,
    parameter int inBits     = 4,
    localparam int accW      = numAdcBits + inBits,
    localparam int bW        = $clog2(inBits + 1)
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic [bW-1:0]                  cfg_in_bits_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [numRows*inBits-1:0]      act_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [numCols*accW-1:0]        result_o,
    output logic                           busy_o,
    output logic                           mac_en_o,
    output logic [numRows-1:0]             data_p_o,
    output logic [numRows-1:0]             data_n_o,
    input  logic [numCols*numAdcBits-1:0]  adc_i,
    input  logic                           sram_req_i,
    input  logic                           sram_busy_i,
    output logic                           sram_gnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                         state_r, state_s;
    logic [numRows*inBits-1:0]      act_r, act_s;
    logic [bW-1:0]                  bits_r, bits_s;
    logic [bW-1:0]                  plane_r, plane_s;
    logic [numCols*accW-1:0]        acc_r, acc_s;
    logic                           last_mac_r, last_mac_s;
    logic                           idle_r;
    logic                           busy_r;
    logic                           mac_en_r;
    logic                           out_valid_r;
    logic [numRows-1:0]             data_p_r, data_p_s;
    logic [numRows-1:0]             data_n_r, data_n_s;
    logic [numRows-1:0]             plane_vec_s;
    logic                           sign_plane_s;
    logic                           in_ready_s;
    logic                           sram_gnt_s;

    // Runtime precision: zero means a single (sign-only) plane, oversize saturates at inBits.
    function automatic logic [bW-1:0] clamp_bits(input logic [bW-1:0] cfg);
        logic [bW-1:0] b;
        if (cfg == {bW{1'b0}}) begin
            b = bW'(1);
        end else if (cfg > bW'(inBits)) begin
            b = bW'(inBits);
        end else begin
            b = cfg;
        end
        return b;
    endfunction

    function automatic logic [numRows-1:0] plane_bits(input logic [numRows*inBits-1:0] act,
                                                      input logic [bW-1:0]             plane);
        logic [numRows-1:0] v;
        v = '0;
        for (int r = 0; r < numRows; r++) begin
            v[r] = act[r*inBits + int'(plane)];
        end
        return v;
    endfunction

    function automatic logic [accW-1:0] adc_ext(input logic [numAdcBits-1:0] code);
        return {{inBits{code[numAdcBits-1]}}, code};
    endfunction

    // Arbitration: whichever requester was not served last wins a same-cycle conflict.
    assign in_ready_s = idle_r & ~sram_busy_i & ~(sram_req_i & last_mac_r);
    assign sram_gnt_s = idle_r & sram_req_i & ~(in_valid_i & ~last_mac_r);

    assign in_ready_o  = in_ready_s;
    assign sram_gnt_o  = sram_gnt_s;
    assign out_valid_o = out_valid_r;
    assign result_o    = acc_r;
    assign busy_o      = busy_r;
    assign mac_en_o    = mac_en_r;
    assign data_p_o    = data_p_r;
    assign data_n_o    = data_n_r;

    // Next-state, plane sequencing, accumulation and arbitration history.
    always_comb begin
        state_s    = state_r;
        act_s      = act_r;
        bits_s     = bits_r;
        plane_s    = plane_r;
        acc_s      = acc_r;
        last_mac_s = last_mac_r;
        case (state_r)
            IDLE: begin
                if (in_valid_i && in_ready_s) begin
                    state_s = DRIVE;
                    act_s   = act_i;
                    bits_s  = clamp_bits(cfg_in_bits_i);
                    plane_s = {bW{1'b0}};
                    acc_s   = '0;
                end else begin
                    state_s = IDLE;
                end
                if (sram_gnt_s) begin
                    last_mac_s = 1'b0;
                end else begin
                    last_mac_s = last_mac_r;
                end
            end
            DRIVE: begin
                state_s = CAPTURE;
            end
            CAPTURE: begin
                // The wrapper registers its ADC, so the plane driven last cycle is on adc_i now.
                for (int c = 0; c < numCols; c++) begin
                    acc_s[c*accW +: accW] = acc_r[c*accW +: accW]
                                          + (adc_ext(adc_i[c*numAdcBits +: numAdcBits]) << plane_r);
                end
                if (plane_r == bits_r - bW'(1)) begin
                    state_s = DONE;
                end else begin
                    plane_s = plane_r + bW'(1);
                    state_s = DRIVE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_s    = IDLE;
                    last_mac_s = 1'b1;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Drive pattern for the upcoming DRIVE cycle; the top plane is the negative-weight sign plane.
    always_comb begin
        sign_plane_s = (plane_s == bits_s - bW'(1));
        plane_vec_s  = plane_bits(act_s, plane_s);
        if (state_s == DRIVE) begin
            if (sign_plane_s) begin
                data_p_s = '0;
                data_n_s = plane_vec_s;
            end else begin
                data_p_s = plane_vec_s;
                data_n_s = '0;
            end
        end else begin
            data_p_s = '0;
            data_n_s = '0;
        end
    end

    // State, datapath and registered outputs; async reset aborts any job in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= IDLE;
            act_r       <= '0;
            bits_r      <= {bW{1'b0}};
            plane_r     <= {bW{1'b0}};
            acc_r       <= '0;
            last_mac_r  <= 1'b1;
            idle_r      <= 1'b0;
            busy_r      <= 1'b0;
            mac_en_r    <= 1'b0;
            out_valid_r <= 1'b0;
            data_p_r    <= '0;
            data_n_r    <= '0;
        end else begin
            state_r     <= state_s;
            act_r       <= act_s;
            bits_r      <= bits_s;
            plane_r     <= plane_s;
            acc_r       <= acc_s;
            last_mac_r  <= last_mac_s;
            idle_r      <= (state_s == IDLE);
            busy_r      <= (state_s != IDLE);
            mac_en_r    <= (state_s == DRIVE);
            out_valid_r <= (state_s == DONE);
            data_p_r    <= data_p_s;
            data_n_r    <= data_n_s;
        end
    end

endmodule

// File: tb/tb_qracc_mac_sequencer.sv
// Bench for qracc_mac_sequencer: per-plane ADC codes come from a table, and expected results are
// the weighted plane sums sum(code[p]*2^p) computed with plain integer arithmetic.
module tb_qracc_mac_sequencer;

    localparam int NR = 128;
    localparam int NC = 32;
    localparam int AB = 4;
    localparam int IB = 4;
    localparam int AW = AB + IB;

    logic                clk = 1'b0;
    logic                nrst;
    logic [2:0]          cfg_in_bits_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [NR*IB-1:0]    act_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [NC*AW-1:0]    result_o;
    logic                busy_o;
    logic                mac_en_o;
    logic [NR-1:0]       data_p_o;
    logic [NR-1:0]       data_n_o;
    logic [NC*AB-1:0]    adc_i = '0;
    logic                sram_req_i;
    logic                sram_busy_i;
    logic                sram_gnt_o;

    int checks = 0;
    int errors = 0;

    logic signed [AB-1:0] code [IB][NC];
    logic [NR*IB-1:0]     act_q;
    int                   mac_cnt = 0;
    int                   base = 0;

    qracc_mac_sequencer dut (
        .clk(clk), .nrst(nrst), .cfg_in_bits_i(cfg_in_bits_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .act_i(act_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .busy_o(busy_o), .mac_en_o(mac_en_o), .data_p_o(data_p_o), .data_n_o(data_n_o),
        .adc_i(adc_i), .sram_req_i(sram_req_i), .sram_busy_i(sram_busy_i),
        .sram_gnt_o(sram_gnt_o)
    );

    always #5 clk = ~clk;

    // Wrapper ADC stand-in: the n-th MAC of a job returns the plane-n code row, one cycle later.
    always @(posedge clk) begin
        if (mac_en_o) begin
            for (int c = 0; c < NC; c++) begin
                adc_i[c*AB +: AB] <= code[(mac_cnt - base) % IB][c];
            end
            mac_cnt <= mac_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*AW-1:0] exp_result(input int beff);
        logic [NC*AW-1:0] res;
        int s;
        res = '0;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int p = 0; p < beff; p++) s += int'(code[p][c]) * (1 << p);
            res[c*AW +: AW] = s[AW-1:0];
        end
        return res;
    endfunction

    function automatic logic [NR-1:0] exp_drive(input int p, input int beff, input bit neg);
        logic [NR-1:0] v;
        v = '0;
        for (int r = 0; r < NR; r++) begin
            if (neg) v[r] = (p == beff - 1) ? act_q[r*IB + p] : 1'b0;
            else     v[r] = (p <  beff - 1) ? act_q[r*IB + p] : 1'b0;
        end
        return v;
    endfunction

    task automatic rand_act();
        for (int i = 0; i < NR*IB/32; i++) act_q[i*32 +: 32] = $urandom;
    endtask

    task automatic rand_codes();
        for (int p = 0; p < IB; p++)
            for (int c = 0; c < NC; c++) code[p][c] = 4'($urandom_range(0, 15));
    endtask

    // Starts at a negedge in IDLE, runs one job, and returns at the negedge of the next IDLE cycle.
    task automatic run_job(input int cfg, input int hold);
        int beff;
        int p;
        logic [NC*AW-1:0] er;
        beff = (cfg == 0) ? 1 : ((cfg > IB) ? IB : cfg);
        er = exp_result(beff);
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_ready", in_ready_o, 1'b1);
        cfg_in_bits_i = 3'(cfg);
        act_i = act_q;
        in_valid_i = 1'b1;
        base = mac_cnt;
        #1 chk("accept_gnt", sram_gnt_o, 1'b0);
        @(negedge clk);
        in_valid_i = 1'b0;
        sram_req_i = 1'b0;
        for (int k = 1; k <= 2*beff; k++) begin
            p = (k - 1) / 2;
            chk("mac_en", mac_en_o, k % 2);
            chk("data_p", data_p_o, (k % 2 == 1) ? exp_drive(p, beff, 1'b0) : '0);
            chk("data_n", data_n_o, (k % 2 == 1) ? exp_drive(p, beff, 1'b1) : '0);
            chk("busy", busy_o, 1'b1);
            chk("early_valid", out_valid_o, 1'b0);
            chk("job_ready", in_ready_o, 1'b0);
            cfg_in_bits_i = 3'($urandom_range(0, 7));
            for (int i = 0; i < NR*IB/32; i++) act_i[i*32 +: 32] = $urandom;
            @(negedge clk);
        end
        chk("valid", out_valid_o, 1'b1);
        chk("result", result_o, er);
        for (int h = 0; h < hold; h++) begin
            out_ready_i = 1'b0;
            in_valid_i = 1'b1;
            sram_req_i = 1'b1;
            @(negedge clk);
            chk("hold_valid", out_valid_o, 1'b1);
            chk("hold_result", result_o, er);
            chk("hold_ready", in_ready_o, 1'b0);
            chk("hold_gnt", sram_gnt_o, 1'b0);
            chk("hold_mac_en", mac_en_o, 1'b0);
        end
        sram_req_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("post_valid", out_valid_o, 1'b0);
        chk("post_busy", busy_o, 1'b0);
    endtask

    initial begin
        nrst = 1'b0;
        cfg_in_bits_i = 3'd4;
        in_valid_i = 1'b0;
        act_i = '0;
        out_ready_i = 1'b0;
        sram_req_i = 1'b0;
        sram_busy_i = 1'b0;
        act_q = '0;
        for (int p = 0; p < IB; p++)
            for (int c = 0; c < NC; c++) code[p][c] = 4'sd0;

        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_mac_en", mac_en_o, 1'b0);
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_data_p", data_p_o, '0);
        chk("rst_data_n", data_n_o, '0);
        chk("rst_result", result_o, '0);
        sram_req_i = 1'b1;
        #1 chk("rst_gnt", sram_gnt_o, 1'b0);
        sram_req_i = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // First conflict after reset goes to SRAM; the next one goes to the MAC job.
        sram_req_i = 1'b1;
        in_valid_i = 1'b1;
        #1;
        chk("arb1_gnt", sram_gnt_o, 1'b1);
        chk("arb1_ready", in_ready_o, 1'b0);
        @(negedge clk);
        sram_busy_i = 1'b1;
        #1 chk("arb_busy_ready", in_ready_o, 1'b0);
        sram_busy_i = 1'b0;
        #1 chk("arb2_gnt", sram_gnt_o, 1'b0);

        act_q = {NR{4'b0011}};
        for (int c = 0; c < NC; c++) begin
            code[0][c] = 4'sd3;
            code[1][c] = 4'sd3;
            code[2][c] = 4'sd0;
            code[3][c] = 4'sd0;
        end
        run_job(4, 0);
        chk("pos_result_9", result_o, {NC{8'd9}});

        act_q = {NR{4'b1000}};
        for (int c = 0; c < NC; c++) begin
            code[0][c] = 4'sd0;
            code[1][c] = 4'sd0;
            code[2][c] = 4'sd0;
            code[3][c] = -4'sd8;
        end
        run_job(4, 5);
        chk("sign_result_m64", result_o, {NC{8'hC0}});

        rand_act();
        rand_codes();
        run_job(0, 0);
        rand_act();
        rand_codes();
        run_job(7, 1);

        for (int j = 0; j < 8; j++) begin
            rand_act();
            rand_codes();
            run_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        // Async reset in the middle of plane 2 of a 4-plane job.
        act_q = '1;
        cfg_in_bits_i = 3'd4;
        act_i = act_q;
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_mac_en", mac_en_o, 1'b1);
        nrst = 1'b0;
        #1;
        chk("abort_mac_en", mac_en_o, 1'b0);
        chk("abort_data_p", data_p_o, '0);
        chk("abort_data_n", data_n_o, '0);
        chk("abort_busy", busy_o, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid_o, 1'b0);
            chk("abort_idle", busy_o, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
